// File: rtl/regfile_port_sequencer_pkg.sv
// Package rv_regfile_pkg: shared types and constants for the register-file
// port sequencer.
//   seq_state_e  : sequencer FSM states (IDLE -> READ -> HOLD)
//   *_LSB        : bit positions of the rs1/rs2/rd fields in an RV32 instruction word
//   REG_ADDR_W   : register index width
//   X0           : index of the hard-wired zero register
//   reg_field()  : extracts a register index field from an instruction word
package rv_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int RD_LSB     = 7;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    function automatic logic [REG_ADDR_W-1:0] reg_field(input logic [31:0] inst,
                                                        input int          lsb);
        return inst[lsb +: REG_ADDR_W];
    endfunction

endpackage

// File: rtl/regfile_port_sequencer_if.sv
// Interface regfile_port_sequencer_if: bundles every non-clock/reset signal of
// the sequencer.
//   inst_*    : instruction channel from the control FSM (valid/ready)
//   op_*, rs*_data_o, rd_o, inst_o : operand hand-off channel (valid/ready)
//   wb_*      : writeback request channel (wb_ready_o is constant 1)
//   rf_*      : register file ports (2 combinational reads, 1 write)
//   op_count_o: completed operand hand-offs, wrapping
// Modports:
//   slave  : the sequencer itself
//   master : the surrounding core / register file side
interface regfile_port_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    import rv_regfile_pkg::*;

    logic                  inst_valid_i;
    logic                  inst_ready_o;
    logic [31:0]           inst_i;
    logic                  op_valid_o;
    logic                  op_ready_i;
    logic [XLEN-1:0]       rs1_data_o;
    logic [XLEN-1:0]       rs2_data_o;
    logic [REG_ADDR_W-1:0] rd_o;
    logic [31:0]           inst_o;
    logic                  wb_valid_i;
    logic                  wb_ready_o;
    logic [REG_ADDR_W-1:0] wb_addr_i;
    logic [XLEN-1:0]       wb_data_i;
    logic [REG_ADDR_W-1:0] rf_aa_o;
    logic [REG_ADDR_W-1:0] rf_ab_o;
    logic [XLEN-1:0]       rf_a_i;
    logic [XLEN-1:0]       rf_b_i;
    logic [REG_ADDR_W-1:0] rf_aw_o;
    logic                  rf_wren_o;
    logic [XLEN-1:0]       rf_wrdata_o;
    logic [CNT_W-1:0]      op_count_o;

    modport slave (
        input  inst_valid_i, inst_i, op_ready_i,
        input  wb_valid_i, wb_addr_i, wb_data_i,
        input  rf_a_i, rf_b_i,
        output inst_ready_o, op_valid_o, rs1_data_o, rs2_data_o, rd_o, inst_o,
        output wb_ready_o, rf_aa_o, rf_ab_o, rf_aw_o, rf_wren_o, rf_wrdata_o,
        output op_count_o
    );

    modport master (
        output inst_valid_i, inst_i, op_ready_i,
        output wb_valid_i, wb_addr_i, wb_data_i,
        output rf_a_i, rf_b_i,
        input  inst_ready_o, op_valid_o, rs1_data_o, rs2_data_o, rd_o, inst_o,
        input  wb_ready_o, rf_aa_o, rf_ab_o, rf_aw_o, rf_wren_o, rf_wrdata_o,
        input  op_count_o
    );

endinterface

// File: rtl/regfile_port_sequencer_bypass.sv
// Module rf_bypass_mux: operand source select for one register read port.
// Picks the write data currently being strobed into the register file when it
// targets the same (non-zero) register as the read, otherwise the register
// file read data.
//   rs      : register index being read
//   aw      : register index of the write strobe
//   wren    : write strobe active
//   rf_data : register file read data for rs
//   wr_data : data of the write strobe
//   operand : selected operand value
module rf_bypass_mux
    import rv_regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] aw,
    input  logic                  wren,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]       operand
);

    logic hit;

    // x0 never bypasses: the register file already returns 0 for it.
    assign hit     = wren && (rs == aw) && (rs != X0);
    assign operand = hit ? wr_data : rf_data;

endmodule

// File: rtl/regfile_port_sequencer.sv
// Module regfile_port_sequencer: client-side driver of a 2-read/1-write
// register file.
//   clk_i : clock, all state on the rising edge
//   rst_i : asynchronous reset, active high
//   bus   : regfile_port_sequencer_if.slave (instruction channel, operand
//           hand-off channel, writeback channel, register file ports, counter)
// An accepted instruction is held in a register that drives the read
// addresses; operands are captured one cycle later (with bypass from the
// write strobe in flight) and held until the consumer takes them.
// Writeback requests are turned into one-cycle registered write strobes
// independently of the instruction FSM.
module regfile_port_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    regfile_port_sequencer_if.slave bus
);
    import rv_regfile_pkg::*;

    localparam int NUM_RS = 2;

    seq_state_e            state_reg;
    seq_state_e            state_next;
    logic                  run_reg;
    logic [31:0]           inst_reg;
    logic [XLEN-1:0]       rs_reg [NUM_RS];
    logic [CNT_W-1:0]      count_reg;
    logic                  wren_reg;
    logic [REG_ADDR_W-1:0] aw_reg;
    logic [XLEN-1:0]       wrdata_reg;

    logic                  inst_ready;
    logic                  op_valid;
    logic                  capture;
    logic                  accept;
    logic                  handoff;
    logic                  wb_hit;

    logic [REG_ADDR_W-1:0] rs_addr  [NUM_RS];
    logic [XLEN-1:0]       rf_rdata [NUM_RS];
    logic [XLEN-1:0]       operand  [NUM_RS];

    // Read addresses come straight from the held instruction register so they
    // never glitch while the register file is being read.
    assign rs_addr[0]  = reg_field(inst_reg, RS1_LSB);
    assign rs_addr[1]  = reg_field(inst_reg, RS2_LSB);
    assign rf_rdata[0] = bus.rf_a_i;
    assign rf_rdata[1] = bus.rf_b_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_bypass
            rf_bypass_mux #(
                .XLEN (XLEN)
            ) u_bypass (
                .rs      (rs_addr[gi]),
                .aw      (aw_reg),
                .wren    (wren_reg),
                .rf_data (rf_rdata[gi]),
                .wr_data (wrdata_reg),
                .operand (operand[gi])
            );
        end
    endgenerate

    assign accept  = bus.inst_valid_i && inst_ready;
    assign handoff = op_valid && bus.op_ready_i;
    assign wb_hit  = bus.wb_valid_i && (bus.wb_addr_i != X0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = HOLD;
            HOLD:    if (handoff) state_next = accept ? READ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        inst_ready = 1'b0;
        op_valid   = 1'b0;
        capture    = 1'b0;
        unique case (state_reg)
            // run_reg keeps ready low while reset is asserted, so no output
            // is high during reset apart from wb_ready_o.
            IDLE:    inst_ready = run_reg;
            READ:    capture    = 1'b1;
            HOLD: begin
                op_valid   = 1'b1;
                inst_ready = bus.op_ready_i;
            end
            default: ;
        endcase
    end

    // ---------------- Instruction / operand datapath ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_reg   <= 1'b0;
            inst_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                rs_reg[i] <= '0;
            end
        end else begin
            run_reg <= 1'b1;
            if (accept) begin
                inst_reg <= bus.inst_i;
            end
            if (capture) begin
                for (int i = 0; i < NUM_RS; i++) begin
                    rs_reg[i] <= operand[i];
                end
            end
            if (handoff) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // ---------------- Writeback stage ----------------
    // One register stage; address/data only move on a real write so the
    // write port stays quiet between strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wren_reg   <= 1'b0;
            aw_reg     <= '0;
            wrdata_reg <= '0;
        end else begin
            wren_reg <= wb_hit;
            if (wb_hit) begin
                aw_reg     <= bus.wb_addr_i;
                wrdata_reg <= bus.wb_data_i;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign bus.inst_ready_o = inst_ready;
    assign bus.op_valid_o   = op_valid;
    assign bus.rs1_data_o   = rs_reg[0];
    assign bus.rs2_data_o   = rs_reg[1];
    assign bus.rd_o         = reg_field(inst_reg, RD_LSB);
    assign bus.inst_o       = inst_reg;
    assign bus.wb_ready_o   = 1'b1;
    assign bus.rf_aa_o      = rs_addr[0];
    assign bus.rf_ab_o      = rs_addr[1];
    assign bus.rf_aw_o      = aw_reg;
    assign bus.rf_wren_o    = wren_reg;
    assign bus.rf_wrdata_o  = wrdata_reg;
    assign bus.op_count_o   = count_reg;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Testbench for regfile_port_sequencer. A 16-bit-counter instance is the
// main DUT; a 4-bit-counter instance shares its stimulus so counter wrap
// can be reached in a short run. A register file model sits behind both.
module tb_regfile_port_sequencer;
    import rv_regfile_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    regfile_port_sequencer_if #(.XLEN(32), .CNT_W(16)) bus ();
    regfile_port_sequencer_if #(.XLEN(32), .CNT_W(4))  bus_w ();

    regfile_port_sequencer #(.XLEN(32), .CNT_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    regfile_port_sequencer #(.XLEN(32), .CNT_W(4)) dut_wrap (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_w)
    );

    // Register file model: combinational reads, x0 reads as zero, cleared by reset.
    logic [31:0] rf_mem [32];
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else if (bus.rf_wren_o) begin
            rf_mem[bus.rf_aw_o] <= bus.rf_wrdata_o;
        end
    end
    assign bus.rf_a_i   = (bus.rf_aa_o == 5'd0) ? 32'd0 : rf_mem[bus.rf_aa_o];
    assign bus.rf_b_i   = (bus.rf_ab_o == 5'd0) ? 32'd0 : rf_mem[bus.rf_ab_o];
    assign bus_w.rf_a_i = (bus_w.rf_aa_o == 5'd0) ? 32'd0 : rf_mem[bus_w.rf_aa_o];
    assign bus_w.rf_b_i = (bus_w.rf_ab_o == 5'd0) ? 32'd0 : rf_mem[bus_w.rf_ab_o];

    assign bus_w.inst_valid_i = bus.inst_valid_i;
    assign bus_w.inst_i       = bus.inst_i;
    assign bus_w.op_ready_i   = bus.op_ready_i;
    assign bus_w.wb_valid_i   = bus.wb_valid_i;
    assign bus_w.wb_addr_i    = bus.wb_addr_i;
    assign bus_w.wb_data_i    = bus.wb_data_i;

    // Scoreboard entry: operands expected for one accepted instruction.
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] inst;
    } ops_t;

    ops_t        sb_q [$];
    logic [31:0] shadow [32];
    seq_state_e  m_state;
    logic        m_run;
    logic [15:0] m_count;
    logic        m_wren;
    logic [4:0]  m_aw;
    logic [31:0] m_wd;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] mk_inst(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] b2b_inst(input int s);
        return mk_inst(5'(3 * s + 1), 5'(7 * s + 2), 5'(s + 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.inst_valid_i = 1'b0;
        bus.inst_i       = 32'd0;
        bus.op_ready_i   = 1'b0;
        bus.wb_valid_i   = 1'b0;
        bus.wb_addr_i    = 5'd0;
        bus.wb_data_i    = 32'd0;
    endtask

    // Asserts reset, checks outputs right away, holds two edges, releases.
    task automatic apply_reset();
        rst_i = 1'b1;
        #1;
        check("rst_inst_ready", 32'(bus.inst_ready_o), 32'd0);
        check("rst_op_valid",   32'(bus.op_valid_o),   32'd0);
        check("rst_rs1",        bus.rs1_data_o,        32'd0);
        check("rst_rs2",        bus.rs2_data_o,        32'd0);
        check("rst_rd",         32'(bus.rd_o),         32'd0);
        check("rst_inst_o",     bus.inst_o,            32'd0);
        check("rst_wb_ready",   32'(bus.wb_ready_o),   32'd1);
        check("rst_rf_aa",      32'(bus.rf_aa_o),      32'd0);
        check("rst_rf_ab",      32'(bus.rf_ab_o),      32'd0);
        check("rst_rf_aw",      32'(bus.rf_aw_o),      32'd0);
        check("rst_rf_wren",    32'(bus.rf_wren_o),    32'd0);
        check("rst_rf_wrdata",  bus.rf_wrdata_o,       32'd0);
        check("rst_op_count",   32'(bus.op_count_o),   32'd0);
        check("rst_op_count_w", 32'(bus_w.op_count_o), 32'd0);
        drive_idle();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        m_state = IDLE;
        m_run   = 1'b0;
        m_count = 16'd0;
        m_wren  = 1'b0;
        m_aw    = 5'd0;
        m_wd    = 32'd0;
        sb_q.delete();
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        $display("reset applied and released at %0t", $time);
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge against
    // the behavioural model, then advance the model across the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] inst, input logic ordy,
                         input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        logic exp_ready, exp_valid, accept, handoff;
        ops_t head;
        ops_t entry;
        bus.inst_valid_i = iv;
        bus.inst_i       = inst;
        bus.op_ready_i   = ordy;
        bus.wb_valid_i   = wv;
        bus.wb_addr_i    = wa;
        bus.wb_data_i    = wd;
        @(negedge clk_i);
        exp_valid = (m_state == HOLD);
        exp_ready = m_run && ((m_state == IDLE) || ((m_state == HOLD) && ordy));
        check("inst_ready", 32'(bus.inst_ready_o), 32'(exp_ready));
        check("op_valid",   32'(bus.op_valid_o),   32'(exp_valid));
        check("rf_wren",    32'(bus.rf_wren_o),    32'(m_wren));
        check("wb_ready",   32'(bus.wb_ready_o),   32'd1);
        check("op_count",   32'(bus.op_count_o),   32'(m_count));
        check("op_count_w", 32'(bus_w.op_count_o), 32'(m_count[3:0]));
        if (m_wren) begin
            check("rf_aw",     32'(bus.rf_aw_o), 32'(m_aw));
            check("rf_wrdata", bus.rf_wrdata_o,  m_wd);
            $display("write strobe x%0d <= 0x%08h", bus.rf_aw_o, bus.rf_wrdata_o);
        end
        if (exp_valid && (sb_q.size() != 0)) begin
            head = sb_q[0];
            check("rs1_data", bus.rs1_data_o,  head.rs1);
            check("rs2_data", bus.rs2_data_o,  head.rs2);
            check("rd",       32'(bus.rd_o),   32'(head.rd));
            check("inst_o",   bus.inst_o,      head.inst);
            check("rf_aa",    32'(bus.rf_aa_o), 32'(head.inst[19:15]));
            check("rf_ab",    32'(bus.rf_ab_o), 32'(head.inst[24:20]));
        end
        accept  = iv && exp_ready;
        handoff = exp_valid && ordy;
        if (handoff) begin
            $display("handoff %0d: rs1=0x%08h rs2=0x%08h rd=%0d", m_count + 16'd1,
                     bus.rs1_data_o, bus.rs2_data_o, bus.rd_o);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            m_count = m_count + 16'd1;
        end
        // Writes sampled at or before the accept edge are visible to the
        // following READ (by bypass or through the register file).
        if (wv && (wa != 5'd0)) shadow[wa] = wd;
        if (accept) begin
            entry.rs1  = shadow[inst[19:15]];
            entry.rs2  = shadow[inst[24:20]];
            entry.rd   = inst[11:7];
            entry.inst = inst;
            sb_q.push_back(entry);
        end
        case (m_state)
            IDLE:    if (accept) m_state = READ;
            READ:    m_state = HOLD;
            HOLD:    if (handoff) m_state = accept ? READ : IDLE;
            default: m_state = IDLE;
        endcase
        m_wren = wv && (wa != 5'd0);
        if (m_wren) begin
            m_aw = wa;
            m_wd = wd;
        end
        m_run = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    // Single instruction, optional write at the accept edge, taken at once in HOLD.
    task automatic one_instr(input logic [31:0] inst, input logic wv, input logic [4:0] wa,
                             input logic [31:0] wd);
        cycle(1'b1, inst, 1'b0, wv, wa, wd);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    // n instructions back to back; each READ cycle rewrites the next one's rs1.
    task automatic run_b2b(input int n, input int seed);
        logic [31:0] nxt;
        cycle(1'b1, b2b_inst(seed), 1'b0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < n; k++) begin
            nxt = b2b_inst(seed + k + 1);
            cycle(1'b0, 32'd0, 1'b0, 1'b1, nxt[19:15], 32'h1000 + 32'(seed + k));
            cycle(k < n - 1, nxt, 1'b1, 1'b0, 5'd0, 32'd0);
        end
    endtask

    initial begin
        drive_idle();
        #1;
        apply_reset();

        // Preload x5, x6 through the writeback path.
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h11);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 5'd6, 32'h22);
        idle_cycles(1);

        // Plain read: rs1=5 rs2=6 rd=7.
        one_instr(mk_inst(5'd5, 5'd6, 5'd7), 1'b0, 5'd0, 32'd0);
        check("count_after_first", 32'(bus.op_count_o), 32'd1);

        // Bypass on rs1, on rs2, and on both with rs1==rs2.
        one_instr(mk_inst(5'd5, 5'd6, 5'd8), 1'b1, 5'd5, 32'hAAAA);
        one_instr(mk_inst(5'd5, 5'd6, 5'd8), 1'b1, 5'd6, 32'hBBBB);
        one_instr(mk_inst(5'd5, 5'd5, 5'd8), 1'b1, 5'd5, 32'hCCCC);

        // Write to x0 never strobes; rs1=0 reads zero.
        one_instr(mk_inst(5'd0, 5'd6, 5'd1), 1'b1, 5'd0, 32'hDEAD);
        idle_cycles(2);
        check("rs1_x0", bus.rs1_data_o, 32'd0);

        // Strobe live in the IDLE accept cycle: READ sees it via the register file.
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 5'd10, 32'hA10);
        one_instr(mk_inst(5'd10, 5'd0, 5'd4), 1'b0, 5'd0, 32'd0);

        // Consumer stalls 5 cycles in HOLD while a new instruction waits;
        // a write landing during HOLD must not disturb the held operands.
        cycle(1'b1, mk_inst(5'd6, 5'd5, 5'd9), 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, mk_inst(5'd6, 5'd6, 5'd12), 1'b0, 1'b1, 5'd6, 32'h77);
        for (int i = 0; i < 4; i++) cycle(1'b1, mk_inst(5'd6, 5'd6, 5'd12), 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, mk_inst(5'd6, 5'd6, 5'd12), 1'b1, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        check("count_after_stall", 32'(bus.op_count_o), 32'd8);

        // Four back-to-back instructions.
        run_b2b(4, 1);
        check("count_after_b2b", 32'(bus.op_count_o), 32'd12);

        // Four more: 16 hand-offs in total, the 4-bit counter wraps to 0.
        run_b2b(4, 6);
        check("count_16", 32'(bus.op_count_o), 32'd16);
        check("count_wrap", 32'(bus_w.op_count_o), 32'd0);
        idle_cycles(1);

        // Reset while in READ with a write strobe live and another request pending.
        cycle(1'b1, mk_inst(5'd5, 5'd6, 5'd3), 1'b0, 1'b1, 5'd5, 32'hF00D);
        bus.wb_valid_i = 1'b1;
        bus.wb_addr_i  = 5'd9;
        bus.wb_data_i  = 32'h0BAD;
        apply_reset();
        idle_cycles(3);
        one_instr(mk_inst(5'd5, 5'd9, 5'd2), 1'b0, 5'd0, 32'd0);
        check("count_after_reset", 32'(bus.op_count_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
